// File: rtl/mem_stage_pkg.sv
// Shared widths and bus layouts for the memory-access stage of the in-order MIPS pipeline.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 72;
    localparam int MS_TO_WS_BUS_WD = 70;

    // Execute-to-memory bus, MSB first.
    typedef struct packed {
        logic        dest_type;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    // Memory-to-writeback bus, MSB first.
    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

endpackage

// File: rtl/mem_stage.sv
// Memory-access stage: pairs each load with next-cycle SRAM data, holds that data
// across writeback stalls, and drives the writeback bus plus forwarding taps.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic [4:0]                 reg_dest_ms,
    output logic [31:0]                ms_value
);

    // Handshake: a transfer happens on an edge where the producer's valid and the
    // consumer's allowin are both high; valid never depends on the consumer's allowin.
    logic        ms_valid;
    logic        first;
    logic        buf_valid;
    logic [31:0] rdata_buf;
    es_to_ms_t   bus_r;
    ms_to_ws_t   ms_out;

    logic        ms_ready_go;
    logic        accept;
    logic        retire;
    logic        capture;
    logic [31:0] mem_result;
    logic [31:0] final_result;
    logic        unused_dest_type;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    assign accept  = es_to_ms_valid && ms_allowin;
    assign retire  = ms_to_ws_valid && ws_allowin;
    // Execute keeps the SRAM enabled, so the load data is only valid in the first
    // cycle; grab it if writeback is not taking the instruction right away.
    assign capture = ms_valid && first && bus_r.res_from_mem && !ws_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid  <= 1'b0;
            first     <= 1'b0;
            buf_valid <= 1'b0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            first <= accept;
            if (accept || retire) begin
                buf_valid <= 1'b0;
            end else if (capture) begin
                buf_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            bus_r <= es_to_ms_t'(es_to_ms_bus);
        end
        if (capture) begin
            rdata_buf <= data_sram_rdata;
        end
    end

    assign mem_result   = buf_valid ? rdata_buf : data_sram_rdata;
    assign final_result = bus_r.res_from_mem ? mem_result : bus_r.alu_result;

    always_comb begin
        ms_out              = '0;
        ms_out.gr_we        = bus_r.gr_we;
        ms_out.dest         = bus_r.dest;
        ms_out.final_result = final_result;
        ms_out.pc           = bus_r.pc;
    end

    assign ms_to_ws_bus     = ms_out;
    assign reg_dest_ms      = (ms_valid && bus_r.gr_we) ? bus_r.dest : 5'd0;
    assign ms_value         = final_result;
    assign unused_dest_type = bus_r.dest_type;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed vectors plus a retire-order scoreboard.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [71:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [31:0] data_sram_rdata;
    logic [4:0]  reg_dest_ms;
    logic [31:0] ms_value;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .data_sram_rdata (data_sram_rdata),
        .reg_dest_ms     (reg_dest_ms),
        .ms_value        (ms_value)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [71:0] make_es(input logic rfm, input logic we, input logic [4:0] dest,
                                            input logic [31:0] alu, input logic [31:0] pc);
        make_es = {1'b0, rfm, we, dest, alu, pc};
    endfunction

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ev, input logic [71:0] bus, input logic wa, input logic [31:0] rd);
        es_to_ms_valid  = ev;
        es_to_ms_bus    = bus;
        ws_allowin      = wa;
        data_sram_rdata = rd;
        #2;
    endtask

    // scoreboard: every retire must match the next expected final_result
    always @(negedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            if (exp_q.size() == 0) begin
                check_eq("scb_unexpected_retire", 72'(ms_to_ws_bus[63:32]), 72'h0);
            end else begin
                check_eq("scb_retire", 72'(ms_to_ws_bus[63:32]), 72'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, 1'b1, 32'h0);
        next_cycle();
        next_cycle();
        check_eq("rst_valid",   72'(ms_to_ws_valid), 72'd0);
        check_eq("rst_allowin", 72'(ms_allowin),     72'd1);
        check_eq("rst_dest",    72'(reg_dest_ms),    72'd0);
        reset = 1'b0;

        // back-to-back loads
        exp_q.push_back(32'hAAAA0001);
        exp_q.push_back(32'hBBBB0002);
        drive(1'b1, make_es(1'b1, 1'b1, 5'd2, 32'h1000, 32'h10), 1'b1, 32'h0);
        next_cycle();
        drive(1'b1, make_es(1'b1, 1'b1, 5'd3, 32'h1004, 32'h14), 1'b1, 32'hAAAA0001);
        check_eq("b2b_res0",     72'(ms_to_ws_bus[63:32]), 72'hAAAA0001);
        check_eq("b2b_pc0",      72'(ms_to_ws_bus[31:0]),  72'h10);
        check_eq("b2b_allowin0", 72'(ms_allowin),          72'd1);
        next_cycle();
        drive(1'b0, '0, 1'b1, 32'hBBBB0002);
        check_eq("b2b_res1",     72'(ms_to_ws_bus[63:32]), 72'hBBBB0002);
        check_eq("b2b_pc1",      72'(ms_to_ws_bus[31:0]),  72'h14);
        check_eq("b2b_valid1",   72'(ms_to_ws_valid),      72'd1);
        next_cycle();
        drive(1'b0, '0, 1'b1, 32'h0);
        check_eq("b2b_empty", 72'(ms_to_ws_valid), 72'd0);

        // load stalled three cycles
        exp_q.push_back(32'h12345678);
        drive(1'b1, make_es(1'b1, 1'b1, 5'd9, 32'h2000, 32'h20), 1'b1, 32'h0);
        next_cycle();
        drive(1'b0, '0, 1'b0, 32'h12345678);
        check_eq("stall_res_c0",  72'(ms_value),   72'h12345678);
        check_eq("stall_allowin", 72'(ms_allowin), 72'd0);
        for (int i = 1; i < 3; i++) begin
            next_cycle();
            drive(1'b0, '0, 1'b0, 32'hDEADBEEF);
            check_eq($sformatf("stall_res_c%0d", i), 72'(ms_to_ws_bus[63:32]), 72'h12345678);
            check_eq($sformatf("stall_buf_c%0d", i), 72'(dut.buf_valid), 72'd1);
        end
        next_cycle();
        drive(1'b0, '0, 1'b1, 32'hDEADBEEF);
        check_eq("stall_res_retire", 72'(ms_to_ws_bus[63:32]), 72'h12345678);
        next_cycle();
        drive(1'b0, '0, 1'b1, 32'h0);
        check_eq("stall_buf_clear", 72'(dut.buf_valid),  72'd0);
        check_eq("stall_done",      72'(ms_to_ws_valid), 72'd0);

        // ALU op followed by a store
        exp_q.push_back(32'h42);
        exp_q.push_back(32'h3000);
        drive(1'b1, make_es(1'b0, 1'b1, 5'd5, 32'h42, 32'h24), 1'b1, 32'hFFFF0000);
        next_cycle();
        drive(1'b1, make_es(1'b0, 1'b0, 5'd7, 32'h3000, 32'h28), 1'b1, 32'hFFFF0000);
        check_eq("alu_res",   72'(ms_to_ws_bus[63:32]), 72'h42);
        check_eq("alu_dest",  72'(reg_dest_ms),         72'd5);
        check_eq("alu_value", 72'(ms_value),            72'h42);
        check_eq("alu_we",    72'(ms_to_ws_bus[69:64]), 72'({1'b1, 5'd5}));
        next_cycle();
        drive(1'b0, '0, 1'b1, 32'h0);
        check_eq("st_valid", 72'(ms_to_ws_valid), 72'd1);
        check_eq("st_dest",  72'(reg_dest_ms),    72'd0);
        next_cycle();

        // reset while a load is stalled
        drive(1'b1, make_es(1'b1, 1'b1, 5'd4, 32'h4000, 32'h30), 1'b1, 32'h0);
        next_cycle();
        drive(1'b0, '0, 1'b0, 32'h11112222);
        next_cycle();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 32'h33334444);
        next_cycle();
        reset = 1'b0;
        drive(1'b0, '0, 1'b1, 32'h33334444);
        check_eq("rst_stall_valid",   72'(ms_to_ws_valid), 72'd0);
        check_eq("rst_stall_dest",    72'(reg_dest_ms),    72'd0);
        check_eq("rst_stall_allowin", 72'(ms_allowin),     72'd1);
        check_eq("rst_stall_buf",     72'(dut.buf_valid),  72'd0);
        exp_q.push_back(32'h55556666);
        drive(1'b1, make_es(1'b1, 1'b1, 5'd4, 32'h4004, 32'h34), 1'b1, 32'h0);
        next_cycle();
        drive(1'b0, '0, 1'b1, 32'h55556666);
        check_eq("post_rst_fresh", 72'(ms_value), 72'h55556666);
        next_cycle();

        // retire and accept on the same edge after a stalled load
        exp_q.push_back(32'h99990000);
        exp_q.push_back(32'h7);
        drive(1'b1, make_es(1'b1, 1'b1, 5'd6, 32'h5000, 32'h40), 1'b1, 32'h0);
        next_cycle();
        drive(1'b0, '0, 1'b0, 32'h99990000);
        next_cycle();
        drive(1'b0, '0, 1'b0, 32'h0BAD0BAD);
        check_eq("ra_buf_set", 72'(dut.buf_valid), 72'd1);
        next_cycle();
        drive(1'b1, make_es(1'b0, 1'b1, 5'd8, 32'h7, 32'h44), 1'b1, 32'h0BAD0BAD);
        check_eq("ra_allowin", 72'(ms_allowin), 72'd1);
        check_eq("ra_old_res", 72'(ms_value),   72'h99990000);
        next_cycle();
        drive(1'b0, '0, 1'b1, 32'hCAFEF00D);
        check_eq("ra_new_res",  72'(ms_to_ws_bus[63:32]), 72'h7);
        check_eq("ra_new_dest", 72'(reg_dest_ms),         72'd8);
        check_eq("ra_buf_clr",  72'(dut.buf_valid),       72'd0);
        check_eq("ra_valid",    72'(ms_to_ws_valid),      72'd1);
        next_cycle();
        drive(1'b0, '0, 1'b1, 32'h0);
        next_cycle();

        // final report
        check_eq("scb_drained", 72'(exp_q.size()), 72'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
